johnson_seq_ctrl: RTL

Command-driven sequencer for a BITS-wide Johnson counter. It accepts a move command (step count, direction, rate divider) and advances the counter one state per prescaled tick. It reports busy/done and holds position between commands. It sits between a host/control FSM and phase-driven loads (stepper phases, multiphase enables) that consume Q directly.

---
 rtl/jseq_pkg.sv | 27 ++
 rtl/johnson_core.sv | 42 ++++
 rtl/johnson_seq_ctrl.sv | 132 +++++++++++++
 3 files changed

// File: rtl/jseq_pkg.sv
// ============================================================================
// Module      : jseq_pkg
// Description : Shared types and helpers for the Johnson sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package jseq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;

    // A legal Johnson word has at most one boundary between its run of ones and its run of zeros.
    // The caller passes the adjacent-bit XOR vector, zero-extended.
    function automatic logic is_legal_johnson(input logic [63:0] edges);
        return ($countones(edges) <= 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/johnson_core.sv
// ============================================================================
// Module      : johnson_core
// Description : Johnson position register with forward/reverse shift and clear.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module johnson_core
    import jseq_pkg::*;
#(
    parameter int BITS = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            adv,
    input  logic            dir,
    input  logic            clr,
    output logic [BITS-1:0] Q
);

    logic [BITS-1:0] r_q;
    logic [BITS-1:0] w_fwd;
    logic [BITS-1:0] w_rev;

    assign w_fwd = {r_q[BITS-2:0], ~r_q[BITS-1]};
    assign w_rev = {~r_q[0], r_q[BITS-1:1]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (adv) begin
            r_q <= (dir == DIR_REV) ? w_rev : w_fwd;
        end
    end

    assign Q = r_q;

endmodule

`default_nettype wire

// File: rtl/johnson_seq_ctrl.sv
// ============================================================================
// Module      : johnson_seq_ctrl
// Description : Command-driven Johnson counter sequencer (steps/dir/rate).
//               Optional JSEQ_SELF_CORRECT_EN adds illegal-state recovery.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module johnson_seq_ctrl
    import jseq_pkg::*;
#(
    parameter int BITS  = 4,
    parameter int CNT_W = 16,
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] steps,
    input  logic             dir,
    input  logic [DIV_W-1:0] div,
    input  logic             abort,
    output logic [BITS-1:0]  Q,
    output logic             busy,
    output logic             done,
    output logic             step_tick,
    output logic             illegal
);

    state_t           r_state;
    logic [CNT_W-1:0] r_remaining;
    logic [DIV_W-1:0] r_prescale;
    logic [DIV_W-1:0] r_div;
    logic             r_dir;
    logic             r_busy;
    logic             r_done;
    logic             r_step_tick;
    logic             r_illegal;

    logic             w_illegal;
    logic             w_due;
    logic             w_adv;

`ifdef JSEQ_SELF_CORRECT_EN
    logic [BITS-2:0]  w_edges;
    assign w_edges   = Q[BITS-2:0] ^ Q[BITS-1:1];
    assign w_illegal = ~is_legal_johnson(64'(w_edges));
`else
    assign w_illegal = 1'b0;
`endif

    // Abort and recovery both suppress an advance that falls due on the same edge.
    assign w_due = (r_prescale == r_div);
    assign w_adv = (r_state == RUN) && w_due && !abort && !w_illegal;

    johnson_core #(
        .BITS (BITS)
    ) u_core (
        .clk   (clk),
        .reset (reset),
        .adv   (w_adv),
        .dir   (r_dir),
        .clr   (w_illegal),
        .Q     (Q)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_remaining <= '0;
            r_prescale  <= '0;
            r_div       <= '0;
            r_dir       <= DIR_FWD;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_step_tick <= 1'b0;
            r_illegal   <= 1'b0;
        end else begin
            r_done      <= 1'b0;
            r_step_tick <= w_adv;
            r_illegal   <= w_illegal;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_remaining <= steps;
                        r_dir       <= dir;
                        r_div       <= div;
                        r_prescale  <= '0;
                        if (steps != '0) begin
                            r_state <= RUN;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (abort || w_illegal) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_due) begin
                        r_prescale  <= '0;
                        r_remaining <= r_remaining - CNT_W'(1);
                        if (r_remaining == CNT_W'(1)) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_prescale <= r_prescale + DIV_W'(1);
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign step_tick = r_step_tick;
    assign illegal   = r_illegal;

endmodule

`default_nettype wire
